// File: rtl/kernel_bc_fifo_srl_param.sv
// Parametrised shift-register FIFO with occupancy count,
// almost-full/empty thresholds, flush and sticky error flags.
module kernel_bc_fifo_srl_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_flush,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_WIDTH-1:0]  if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [DATA_WIDTH-1:0] srl_d [DEPTH];

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 empty_n_q, empty_n_d;
  logic                 full_n_q, full_n_d;
  logic                 af_q, af_d;
  logic                 ae_q, ae_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic                 wr_req, rd_req;
  logic                 wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_WIDTH-1:0] cnt_m1;

  assign wr_req = if_write & if_write_ce & ~if_flush;
  assign rd_req = if_read & if_read_ce & ~if_flush;
  assign wr_acc = wr_req & full_n_q;
  assign rd_acc = rd_req & empty_n_q;

  assign cnt_m1  = count_q - CNT_ONE;
  assign rd_addr = empty_n_q ? cnt_m1[ADDR_WIDTH-1:0] : '0;

  assign if_dout         = srl_q[rd_addr];
  assign if_full_n       = full_n_q;
  assign if_empty_n      = empty_n_q;
  assign if_count        = count_q;
  assign if_almost_full  = af_q;
  assign if_almost_empty = ae_q;
  assign if_overflow     = ovf_q;
  assign if_underflow    = udf_q;

  // Shift a new word in at the head on every accepted write
  always_comb begin
    srl_d = srl_q;
    if (wr_acc) begin
      for (int i = DEPTH - 1; i > 0; i--) srl_d[i] = srl_q[i-1];
      srl_d[0] = if_din;
    end
  end

  // Next occupancy, registered status flags and sticky errors
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (if_flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
      if (rd_acc && !wr_acc) count_d = cnt_m1;
      if (wr_req && !full_n_q)  ovf_d = 1'b1;
      if (rd_req && !empty_n_q) udf_d = 1'b1;
    end
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != CNT_FULL);
    af_d      = (count_d >= CNT_AF);
    ae_d      = (count_d <= CNT_AE);
  end

  // Storage array: no reset, contents survive flush
  always_ff @(posedge clk) begin
    srl_q <= srl_d;
  end

  // Control state with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_q      <= (AF_THRESH <= 0);
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

endmodule

// File: tb/tb_kernel_bc_fifo_srl_param.sv
// Directed self-checking bench for kernel_bc_fifo_srl_param
// (DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1).
module tb_kernel_bc_fifo_srl_param;

  localparam int DW = 8;
  localparam int DP = 5;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          if_flush;
  logic          if_write;
  logic          if_write_ce;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read;
  logic          if_read_ce;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [CW-1:0] if_count;
  logic          if_almost_full;
  logic          if_almost_empty;
  logic          if_overflow;
  logic          if_underflow;

  int total = 0;
  int bad   = 0;

  kernel_bc_fifo_srl_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .AF_THRESH (4),
    .AE_THRESH (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_flush       (if_flush),
    .if_write       (if_write),
    .if_write_ce    (if_write_ce),
    .if_din         (if_din),
    .if_full_n      (if_full_n),
    .if_read        (if_read),
    .if_read_ce     (if_read_ce),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .if_count       (if_count),
    .if_almost_full (if_almost_full),
    .if_almost_empty(if_almost_empty),
    .if_overflow    (if_overflow),
    .if_underflow   (if_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // status: {empty_n, full_n, af, ae, ovf, udf}
  task automatic chk_st(input string tag, input int cnt,
                        input logic [5:0] st);
    chk({tag, ".count"}, 32'(if_count), 32'(cnt));
    chk({tag, ".status"},
        {26'd0, if_empty_n, if_full_n, if_almost_full,
         if_almost_empty, if_overflow, if_underflow},
        {26'd0, st});
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic f);
    if_write = w;
    if_din   = d;
    if_read  = r;
    if_flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] v;

  initial begin
    reset       = 1'b1;
    if_write_ce = 1'b1;
    if_read_ce  = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_st("reset", 0, 6'b010100);

    // Fill 0x11..0x55
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    chk_st("fill1", 1, 6'b110100);
    chk("fill1.dout", 32'(if_dout), 32'h11);
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    chk_st("fill2", 2, 6'b110000);
    drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
    chk_st("fill3", 3, 6'b110000);
    drive(1'b1, 8'h44, 1'b0, 1'b0); tick();
    chk_st("fill4", 4, 6'b111000);
    drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
    chk_st("fill5", 5, 6'b101000);
    chk("fill5.dout", 32'(if_dout), 32'h11);

    // Drain
    for (int k = 0; k < 5; k++) begin
      v = DW'((k + 1) * 8'h11);
      chk("drain.dout", 32'(if_dout), 32'(v));
      drive(1'b0, '0, 1'b1, 1'b0); tick();
      chk("drain.count", 32'(if_count), 32'(4 - k));
    end
    chk_st("drain_end", 0, 6'b010100);

    // Simultaneous read+write at count 2
    drive(1'b1, 8'hA0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hA1, 1'b0, 1'b0); tick();
    chk("sim.pre", 32'(if_count), 32'd2);
    chk("sim.d0", 32'(if_dout), 32'hA0);
    drive(1'b1, 8'hB0, 1'b1, 1'b0); tick();
    chk("sim.c0", 32'(if_count), 32'd2);
    chk("sim.d1", 32'(if_dout), 32'hA1);
    drive(1'b1, 8'hB1, 1'b1, 1'b0); tick();
    chk("sim.c1", 32'(if_count), 32'd2);
    chk("sim.d2", 32'(if_dout), 32'hB0);
    drive(1'b1, 8'hB2, 1'b1, 1'b0); tick();
    chk("sim.d3", 32'(if_dout), 32'hB1);
    drive(1'b1, 8'hB3, 1'b1, 1'b0); tick();
    chk_st("sim.end", 2, 6'b110000);
    chk("sim.d4", 32'(if_dout), 32'hB2);

    // Fill to full: B2,B3,C0,C1,C2
    drive(1'b1, 8'hC0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
    chk_st("full", 5, 6'b101000);

    // Overflow: write while full
    drive(1'b1, 8'hD0, 1'b0, 1'b0); tick();
    chk_st("ovf", 5, 6'b101010);
    chk("ovf.dout", 32'(if_dout), 32'hB2);

    // Read+write at full: only the read is taken
    drive(1'b1, 8'hE0, 1'b1, 1'b0); tick();
    chk_st("rw_full", 4, 6'b111010);
    chk("rw_full.dout", 32'(if_dout), 32'hB3);

    // Flush clears everything
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk_st("flush", 0, 6'b010100);

    // Underflow: read while empty
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk_st("udf", 0, 6'b010101);

    // Read+write at empty: only the write is taken
    drive(1'b1, 8'h5A, 1'b1, 1'b0); tick();
    chk_st("rw_empty", 1, 6'b110101);
    chk("rw_empty.dout", 32'(if_dout), 32'h5A);

    // Flush priority with count 3
    drive(1'b1, 8'h61, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h62, 1'b0, 1'b0); tick();
    chk("fp.pre", 32'(if_count), 32'd3);
    drive(1'b1, 8'h63, 1'b1, 1'b1); tick();
    chk_st("fp", 0, 6'b010100);
    drive(1'b1, 8'h77, 1'b0, 1'b0); tick();
    chk_st("fp.wr", 1, 6'b110100);
    chk("fp.dout", 32'(if_dout), 32'h77);

    // Write clock-enable low blocks the write
    if_write_ce = 1'b0;
    drive(1'b1, 8'h88, 1'b0, 1'b0); tick();
    if_write_ce = 1'b1;
    chk("ce.count", 32'(if_count), 32'd1);

    // Reset mid-stream with a write pending
    reset = 1'b1;
    drive(1'b1, 8'h99, 1'b0, 1'b0); tick();
    reset = 1'b0;
    chk_st("rst_mid", 0, 6'b010100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
